// File: rtl/can_pkg.sv
// Shared types and default widths for the CAN bit-timing logic.
package can_pkg;

  localparam int BRP_W   = 8;
  localparam int TSEG1_W = 4;
  localparam int TSEG2_W = 3;
  localparam int SJW_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC_SEG = 2'd1,
    TSEG1    = 2'd2,
    TSEG2    = 2'd3
  } btl_state_e;

endpackage

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: divides clk_ref by (brp+1) and strobes on the
// last clk of every quantum. Held at zero while the controller is stopped
// so the first quantum after a start is always full length.
module can_tq_prescaler #(
  parameter int BRP_W = can_pkg::BRP_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [BRP_W-1:0] i_brp,
  output logic             o_tick
);

  logic [BRP_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == i_brp);
  assign o_tick = i_run && w_last;

  // Count 0..brp and wrap; clear whenever stopped or in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BRP_W'(1);
    end
  end

endmodule

// File: rtl/can_btl_ctrl.sv
// CAN bit-timing controller: sequences SYNC_SEG/TSEG1/TSEG2 in time quanta,
// applies hard sync and SJW-limited resync on recessive-to-dominant edges,
// and produces bit-start / sample-point strobes with the sampled bit.
// Strobes are registered and appear in the same clk as the new state_o.
module can_btl_ctrl #(
  parameter int BRP_W   = can_pkg::BRP_W,
  parameter int TSEG1_W = can_pkg::TSEG1_W,
  parameter int TSEG2_W = can_pkg::TSEG2_W,
  parameter int SJW_W   = can_pkg::SJW_W
) (
  input  logic               i_clk_ref,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [BRP_W-1:0]   i_brp,
  input  logic [TSEG1_W-1:0] i_tseg1,
  input  logic [TSEG2_W-1:0] i_tseg2,
  input  logic [SJW_W-1:0]   i_sjw,
  input  logic               i_rx,
  input  logic               i_hard_sync_en,
  output logic               o_tq_tick,
  output logic               o_bit_start,
  output logic               o_sample_pulse,
  output logic               o_rx_bit,
  output logic               o_hard_sync_done,
  output logic [1:0]         o_state
);

  import can_pkg::*;

  // The tq counter must hold tseg1+ext (up to 15+4) as well as tseg2.
  localparam int CNT_W = ((TSEG1_W >= TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;
  localparam int EXT_W = SJW_W + 1;

  // Latched configuration
  logic [BRP_W-1:0]   r_brp_l;
  logic [TSEG1_W-1:0] r_tseg1_l;
  logic [TSEG2_W-1:0] r_tseg2_l;
  logic [SJW_W-1:0]   r_sjw_l;

  // Bit-timing state
  btl_state_e         r_state;
  logic [CNT_W-1:0]   r_tq_cnt;
  logic [EXT_W-1:0]   r_ext;
  logic               r_edge_pend;
  logic               r_resync_done;
  logic               r_rx_prev;
  logic               r_rx_bit;
  logic               r_bit_start;
  logic               r_sample;
  logic               r_hsync_done;

  // Next-state values
  btl_state_e         w_state_nxt;
  logic [CNT_W-1:0]   w_tq_cnt_nxt;
  logic [EXT_W-1:0]   w_ext_nxt;
  logic               w_edge_pend_nxt;
  logic               w_resync_nxt;
  logic               w_rx_bit_nxt;
  logic               w_bit_start_nxt;
  logic               w_sample_nxt;
  logic               w_hsync_nxt;

  // Helpers
  logic               w_tick;
  logic               w_run;
  logic               w_edge;
  logic               w_edge_any;
  logic [EXT_W-1:0]   w_sjw_tq;
  logic [CNT_W-1:0]   w_phase_err;
  logic [EXT_W-1:0]   w_ext_resync;
  logic [CNT_W-1:0]   w_rem;
  logic [EXT_W-1:0]   w_ext_eff;

  assign w_run = i_enable && (r_state != IDLE);

  can_tq_prescaler #(
    .BRP_W (BRP_W)
  ) u_prescaler (
    .i_clk  (i_clk_ref),
    .i_rst  (i_rst),
    .i_run  (w_run),
    .i_brp  (r_brp_l),
    .o_tick (w_tick)
  );

  // A pending edge or one arriving on the tick clk itself is consumed at the tick.
  assign w_edge       = r_rx_prev & ~i_rx;
  assign w_edge_any   = r_edge_pend | w_edge;
  assign w_sjw_tq     = EXT_W'(r_sjw_l) + EXT_W'(1);
  assign w_phase_err  = r_tq_cnt + CNT_W'(1);
  assign w_ext_resync = (w_phase_err > CNT_W'(w_sjw_tq)) ? w_sjw_tq : EXT_W'(w_phase_err);
  assign w_rem        = CNT_W'(r_tseg2_l) - r_tq_cnt;

  // Capture the timing configuration only on the stopped-to-running transition.
  always_ff @(posedge i_clk_ref) begin
    if (i_rst) begin
      r_brp_l   <= '0;
      r_tseg1_l <= '0;
      r_tseg2_l <= '0;
      r_sjw_l   <= '0;
    end else if (i_enable && (r_state == IDLE)) begin
      r_brp_l   <= i_brp;
      r_tseg1_l <= i_tseg1;
      r_tseg2_l <= i_tseg2;
      r_sjw_l   <= i_sjw;
    end
  end

  // State register: stop forces IDLE, a start enters SYNC_SEG with bit_start.
  always_ff @(posedge i_clk_ref) begin
    if (i_rst || !i_enable) begin
      r_state       <= IDLE;
      r_tq_cnt      <= '0;
      r_ext         <= '0;
      r_edge_pend   <= 1'b0;
      r_resync_done <= 1'b0;
      r_rx_prev     <= 1'b1;
      r_rx_bit      <= 1'b1;
      r_bit_start   <= 1'b0;
      r_sample      <= 1'b0;
      r_hsync_done  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_state       <= SYNC_SEG;
      r_tq_cnt      <= '0;
      r_ext         <= '0;
      r_edge_pend   <= 1'b0;
      r_resync_done <= 1'b0;
      r_rx_prev     <= i_rx;
      r_rx_bit      <= 1'b1;
      r_bit_start   <= 1'b1;
      r_sample      <= 1'b0;
      r_hsync_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tq_cnt      <= w_tq_cnt_nxt;
      r_ext         <= w_ext_nxt;
      r_edge_pend   <= w_edge_pend_nxt;
      r_resync_done <= w_resync_nxt;
      r_rx_prev     <= i_rx;
      r_rx_bit      <= w_rx_bit_nxt;
      r_bit_start   <= w_bit_start_nxt;
      r_sample      <= w_sample_nxt;
      r_hsync_done  <= w_hsync_nxt;
    end
  end

  // Next-state logic: segment sequencing and edge handling, evaluated on tq ticks.
  always_comb begin
    w_state_nxt     = r_state;
    w_tq_cnt_nxt    = r_tq_cnt;
    w_ext_nxt       = r_ext;
    w_edge_pend_nxt = r_edge_pend | w_edge;
    w_resync_nxt    = r_resync_done;
    w_rx_bit_nxt    = r_rx_bit;
    w_bit_start_nxt = 1'b0;
    w_sample_nxt    = 1'b0;
    w_hsync_nxt     = 1'b0;
    w_ext_eff       = r_ext;

    if (w_tick) begin
      w_edge_pend_nxt = 1'b0;
      if (w_edge_any && i_hard_sync_en) begin
        // The edge quantum itself serves as SYNC_SEG.
        w_state_nxt     = TSEG1;
        w_tq_cnt_nxt    = '0;
        w_ext_nxt       = '0;
        w_resync_nxt    = 1'b0;
        w_bit_start_nxt = 1'b1;
        w_hsync_nxt     = 1'b1;
      end else begin
        case (r_state)
          SYNC_SEG: begin
            w_state_nxt  = TSEG1;
            w_tq_cnt_nxt = '0;
          end
          TSEG1: begin
            // Late edge: lengthen TSEG1 by the phase error, capped at SJW.
            if (w_edge_any && !r_resync_done) begin
              w_ext_eff    = w_ext_resync;
              w_ext_nxt    = w_ext_resync;
              w_resync_nxt = 1'b1;
            end
            if (r_tq_cnt == (CNT_W'(r_tseg1_l) + CNT_W'(w_ext_eff))) begin
              w_state_nxt  = TSEG2;
              w_tq_cnt_nxt = '0;
              w_sample_nxt = 1'b1;
              w_rx_bit_nxt = i_rx;
              w_resync_nxt = 1'b0;
              w_ext_nxt    = '0;
            end else begin
              w_tq_cnt_nxt = r_tq_cnt + CNT_W'(1);
            end
          end
          TSEG2: begin
            if (w_edge_any && !r_resync_done) begin
              w_resync_nxt = 1'b1;
              if (w_rem <= CNT_W'(w_sjw_tq)) begin
                // Early edge close to the bit end: the edge quantum becomes SYNC_SEG.
                w_state_nxt     = TSEG1;
                w_tq_cnt_nxt    = '0;
                w_bit_start_nxt = 1'b1;
              end else begin
                // Skip SJW quanta; the remaining count still lands on tseg2 exactly.
                w_tq_cnt_nxt = r_tq_cnt + CNT_W'(1) + CNT_W'(w_sjw_tq);
              end
            end else if (r_tq_cnt == CNT_W'(r_tseg2_l)) begin
              w_state_nxt     = SYNC_SEG;
              w_tq_cnt_nxt    = '0;
              w_bit_start_nxt = 1'b1;
            end else begin
              w_tq_cnt_nxt = r_tq_cnt + CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output logic: expose registered strobes and the current state.
  always_comb begin
    o_tq_tick        = w_tick;
    o_bit_start      = r_bit_start;
    o_sample_pulse   = r_sample;
    o_rx_bit         = r_rx_bit;
    o_hard_sync_done = r_hsync_done;
    o_state          = r_state;
  end

endmodule

// File: tb/tb_can_btl_ctrl.sv
// Self-checking bench for can_btl_ctrl: a table of free-running configurations
// plus directed sequences for resync, hard sync and stop/restart corners.
module tb_can_btl_ctrl;

  localparam int SEL_BS   = 0;
  localparam int SEL_SP   = 1;
  localparam int SEL_HS   = 2;
  localparam int SEL_TICK = 3;
  localparam int MAXC     = 300;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] brp;
  logic [3:0] tseg1;
  logic [2:0] tseg2;
  logic [1:0] sjw;
  logic       rx;
  logic       hardSyncEn;
  logic       tqTick;
  logic       bitStart;
  logic       samplePulse;
  logic       rxBit;
  logic       hardSyncDone;
  logic [1:0] state;

  int cyc;
  int nTests;
  int nFail;

  typedef struct {
    int brp;
    int tseg1;
    int tseg2;
    int sjw;
    int rxLevel;
    int expTq;
    int expSample;
    int expBit;
  } vec_t;

  vec_t vecs[5];

  can_btl_ctrl dut (
    .i_clk_ref        (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_brp            (brp),
    .i_tseg1          (tseg1),
    .i_tseg2          (tseg2),
    .i_sjw            (sjw),
    .i_rx             (rx),
    .i_hard_sync_en   (hardSyncEn),
    .o_tq_tick        (tqTick),
    .o_bit_start      (bitStart),
    .o_sample_pulse   (samplePulse),
    .o_rx_bit         (rxBit),
    .o_hard_sync_done (hardSyncDone),
    .o_state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic strobeVal(input int sel);
    case (sel)
      SEL_BS:  return bitStart;
      SEL_SP:  return samplePulse;
      SEL_HS:  return hardSyncDone;
      default: return tqTick;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic stepN(input int n);
    repeat (n) step();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns the cycle stamp of the next strobe, or -1 when the bound expires.
  task automatic waitStrobe(input int sel, input int maxc, output int t);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    t = -1;
    while (!seen && n < maxc) begin
      step();
      n++;
      if (strobeVal(sel)) begin
        seen = 1;
        t = cyc;
      end
    end
  endtask

  // Stop, load a configuration, restart; t0 is the cycle of the first bit_start.
  task automatic applyStimulus(input int b, input int t1, input int t2, input int s,
                               input int rxl, output int t0);
    int tEn;
    enable = 1'b0;
    stepN(2);
    brp        = 8'(b);
    tseg1      = 4'(t1);
    tseg2      = 3'(t2);
    sjw        = 2'(s);
    rx         = 1'(rxl);
    hardSyncEn = 1'b0;
    enable     = 1'b1;
    tEn        = cyc;
    waitStrobe(SEL_BS, 4, t0);
    checkOutput("start_latency", t0 - tEn, 1);
  endtask

  initial begin
    int t0;
    int t;
    int ta;
    int tb;

    cyc    = 0;
    nTests = 0;
    nFail  = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    brp        = '0;
    tseg1      = '0;
    tseg2      = '0;
    sjw        = '0;
    rx         = 1'b1;
    hardSyncEn = 1'b0;

    vecs[0] = '{brp: 3, tseg1: 5,  tseg2: 2, sjw: 1, rxLevel: 1, expTq: 4, expSample: 28, expBit: 40};
    vecs[1] = '{brp: 0, tseg1: 0,  tseg2: 0, sjw: 0, rxLevel: 0, expTq: 1, expSample: 2,  expBit: 3};
    vecs[2] = '{brp: 1, tseg1: 3,  tseg2: 1, sjw: 0, rxLevel: 1, expTq: 2, expSample: 10, expBit: 14};
    vecs[3] = '{brp: 2, tseg1: 15, tseg2: 7, sjw: 3, rxLevel: 0, expTq: 3, expSample: 51, expBit: 75};
    vecs[4] = '{brp: 0, tseg1: 7,  tseg2: 3, sjw: 2, rxLevel: 1, expTq: 1, expSample: 9,  expBit: 13};

    // Reset state
    stepN(3);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_bit_start", int'(bitStart), 0);
    checkOutput("rst_sample", int'(samplePulse), 0);
    checkOutput("rst_hsync", int'(hardSyncDone), 0);
    checkOutput("rst_tick", int'(tqTick), 0);
    checkOutput("rst_rx_bit", int'(rxBit), 1);
    rst = 1'b0;
    step();

    // Free-running table; config inputs are scrambled after start and must be ignored
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].brp, vecs[i].tseg1, vecs[i].tseg2, vecs[i].sjw, vecs[i].rxLevel, t0);
      brp   = ~brp;
      tseg1 = ~tseg1;
      tseg2 = ~tseg2;
      sjw   = ~sjw;
      waitStrobe(SEL_SP, MAXC, t);
      checkOutput($sformatf("v%0d_sample_ofs", i), t - t0, vecs[i].expSample);
      checkOutput($sformatf("v%0d_rx_bit", i), int'(rxBit), vecs[i].rxLevel);
      waitStrobe(SEL_BS, MAXC, t);
      checkOutput($sformatf("v%0d_bit_len", i), t - t0, vecs[i].expBit);
      waitStrobe(SEL_TICK, MAXC, ta);
      waitStrobe(SEL_TICK, MAXC, tb);
      checkOutput($sformatf("v%0d_tq_period", i), tb - ta, vecs[i].expTq);
    end

    // Positive resync: edge at TSEG1 tq 2, clamped to SJW=2; second edge ignored
    applyStimulus(3, 5, 2, 1, 1, t0);
    stepN(13); rx = 1'b0;
    stepN(4);  rx = 1'b1;
    stepN(4);  rx = 1'b0;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("pos_sample_ofs", t - t0, 36);
    checkOutput("pos_rx_bit", int'(rxBit), 0);
    waitStrobe(SEL_BS, MAXC, t);
    checkOutput("pos_bit_len", t - t0, 48);

    // Positive resync of 1 tq; a later larger edge in the same bit must not extend further
    applyStimulus(3, 5, 2, 1, 1, t0);
    stepN(5); rx = 1'b0;
    stepN(3); rx = 1'b1;
    stepN(9); rx = 1'b0;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("pos2_sample_ofs", t - t0, 32);
    waitStrobe(SEL_BS, MAXC, t);
    checkOutput("pos2_bit_len", t - t0, 44);

    // Negative resync: edge at TSEG2 tq 2 jumps straight to TSEG1
    applyStimulus(3, 5, 2, 1, 1, t0);
    stepN(37); rx = 1'b0;
    waitStrobe(SEL_BS, MAXC, t);
    checkOutput("neg_bs_time", t - t0, 40);
    checkOutput("neg_state", int'(state), 2);
    stepN(10); rx = 1'b1;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("neg_sample_ofs", t - t0, 64);
    waitStrobe(SEL_BS, MAXC, tb);
    checkOutput("neg_short_bit", tb - t0, 76);
    checkOutput("neg_sync_state", int'(state), 1);
    // Edge inside SYNC_SEG has no effect
    step(); rx = 1'b0;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("sync_edge_sample", t - tb, 28);
    waitStrobe(SEL_BS, MAXC, t);
    checkOutput("sync_edge_bit", t - tb, 40);

    // TSEG2 shortening: remaining 7 tq > SJW 1 tq
    applyStimulus(0, 3, 7, 0, 1, t0);
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("shrt_sample_ofs", t - t0, 5);
    rx = 1'b0;
    waitStrobe(SEL_BS, MAXC, t);
    checkOutput("shrt_bit_len", t - t0, 12);

    // Hard sync: edge at TSEG2 tq 1
    applyStimulus(3, 5, 2, 1, 1, t0);
    hardSyncEn = 1'b1;
    stepN(33); rx = 1'b0;
    waitStrobe(SEL_HS, MAXC, t);
    checkOutput("hs_time", t - t0, 36);
    checkOutput("hs_bit_start", int'(bitStart), 1);
    checkOutput("hs_state", int'(state), 2);
    tb = t;
    hardSyncEn = 1'b0;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("hs_sample_ofs", t - tb, 24);
    checkOutput("hs_rx_bit", int'(rxBit), 0);

    // Enable drop mid-TSEG1 clears everything on the next clk
    applyStimulus(3, 5, 2, 1, 1, t0);
    rx = 1'b0;
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("dis_pre_rx_bit", int'(rxBit), 0);
    waitStrobe(SEL_BS, MAXC, t);
    stepN(10);
    enable = 1'b0;
    step();
    checkOutput("dis_state", int'(state), 0);
    checkOutput("dis_strobes", int'({bitStart, samplePulse, hardSyncDone, tqTick}), 0);
    checkOutput("dis_rx_bit", int'(rxBit), 1);

    // Restart with tseg1=3: bit = 8 tq
    applyStimulus(3, 3, 2, 1, 1, t0);
    waitStrobe(SEL_SP, MAXC, t);
    checkOutput("re_sample_ofs", t - t0, 20);
    waitStrobe(SEL_BS, MAXC, tb);
    checkOutput("re_bit_len", tb - t0, 32);

    // Synchronous reset mid-TSEG1, then automatic restart while enable stays high
    stepN(6);
    rst = 1'b1;
    step();
    checkOutput("srst_state", int'(state), 0);
    checkOutput("srst_strobes", int'({bitStart, samplePulse, hardSyncDone, tqTick}), 0);
    rst = 1'b0;
    step();
    checkOutput("srst_restart_bs", int'(bitStart), 1);
    checkOutput("srst_restart_state", int'(state), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/can_btl_ctrl.md
Name: can_btl_ctrl

Overview:
CAN bit-timing-logic controller. Sequences every nominal bit through SYNC_SEG / TSEG1 / TSEG2 in time quanta, and applies hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges. It emits bit-start and sample-point strobes plus the sampled bit value. It sits between the BTR config register and the CAN bit-stream engine (tx/rx shift logic).

Parameters:
BRP_W, 8, prescaler width; tq length = brp+1 clk_ref cycles
TSEG1_W, 4, tseg1 field width; TSEG1 length = tseg1+1 tq (1..16)
TSEG2_W, 3, tseg2 field width; TSEG2 length = tseg2+1 tq (1..8)
SJW_W, 2, sjw field width; SJW = sjw+1 tq (1..4)

Ports:
clk_ref  in  1  core clock
rst  in  1  synchronous reset, active-high
enable  in  1  controller run; config is latched on 0->1
brp  in  BRP_W  prescaler value
tseg1  in  TSEG1_W  TSEG1 length minus 1
tseg2  in  TSEG2_W  TSEG2 length minus 1
sjw  in  SJW_W  SJW minus 1
rx_i  in  1  bus level, already synchronous to clk_ref (1 = recessive)
hard_sync_en  in  1  bus idle / SOF window: the next edge hard-syncs
tq_tick  out  1  1-clk strobe at the last clk of each tq
bit_start  out  1  1-clk strobe when a new bit begins
sample_pulse  out  1  1-clk strobe at the sample point
rx_bit  out  1  rx_i captured at the sample point
hard_sync_done  out  1  1-clk strobe when a hard sync is applied
state_o  out  2  current btl_state_e

Behaviour:
- Reset or enable=0: state IDLE, prescaler=0, tq_cnt=0, ext=0, edge_pend=0, resync_done=0. All strobes 0, rx_bit=1, state_o=IDLE. Takes effect the next clk, including mid-bit.
- enable 0->1: latch brp/tseg1/tseg2/sjw. Enter SYNC_SEG with bit_start=1 in the same cycle the state changes. Config changes while enabled are ignored.
- Prescaler: counts 0..brp_l. tq_tick=1 when count==brp_l, then wraps to 0. brp=0 gives tq_tick every clk.
- Edge detect: rx_prev registered each clk. Condition rx_prev=1 and rx_i=0 sets edge_pend.
- edge_pend is consumed, and cleared, on the next tq_tick. An edge arriving on the same clk as tq_tick is consumed at that tick.
- State transitions on tq_tick only, using tq_cnt counting from 0:
  - SYNC_SEG -> TSEG1, tq_cnt=0.
  - TSEG1: when tq_cnt == tseg1_l+ext, go to TSEG2 with tq_cnt=0. On that same tick: sample_pulse=1, rx_bit<=rx_i, resync_done<=0, ext<=0.
  - TSEG2: when tq_cnt == tseg2_l, go to SYNC_SEG with bit_start=1.
- Edge priority at a tick, highest first:
  1. hard_sync_en=1 (any non-IDLE state): go to TSEG1, tq_cnt=0, ext=0, resync_done=0, bit_start=1, hard_sync_done=1. The edge tq counts as SYNC_SEG.
  2. State SYNC_SEG, or resync_done=1: edge ignored.
  3. State TSEG1: phase error e = tq_cnt+1. Set ext = min(e, sjw_l+1) and resync_done=1.
  4. State TSEG2: remaining r = tseg2_l - tq_cnt.
     - If r <= sjw_l+1: go to TSEG1, tq_cnt=0, bit_start=1, resync_done=1. The edge tq acts as SYNC_SEG.
     - Else: shorten the current TSEG2 by sjw_l+1 tq, then resync_done=1.
- Arithmetic: tq_cnt and TSEG1 end compare use TSEG1_W+1 bits; maximum is 15+4=19. No overflow is possible.

Decomposition:
- Shared package can_pkg holds:
  - btl_state_e {IDLE=0, SYNC_SEG=1, TSEG1=2, TSEG2=3}
  - Width localparams BRP_W, TSEG1_W, TSEG2_W, SJW_W, with defaults as above
- Sub-module can_tq_prescaler (counter + tq_tick, clear-on-disable). The FSM and sync logic stay in can_btl_ctrl.

Test Plan:
All scenarios use brp=3, tseg1=5, tseg2=2, sjw=1 unless stated: tq = 4 clk, bit = 10 tq = 40 clk, sample point after 7 tq, SJW = 2 tq.
- Free run, rx_i=1: bit_start every 40 clk. sample_pulse 28 clk after each bit_start. rx_bit=1. tq_tick every 4 clk.
- hard_sync_en=1, falling edge mid-TSEG2: hard_sync_done and bit_start assert on the next tq_tick. sample_pulse follows 24 clk later (6 tq).
- Positive resync: edge in TSEG1 at tq_cnt=2 (e=3, clamped to 2). sample_pulse arrives 8 clk later than nominal (36 clk after bit_start). A second edge in the same bit is ignored.
- Negative resync: edge in TSEG2 at tq_cnt=2 (r=0 <= 2). Goes directly to TSEG1 with bit_start, no SYNC_SEG, so the bit is 36 clk. An edge in SYNC_SEG causes no change.
- brp=0, tseg1=0, tseg2=0: tq_tick every clk, bit = 3 clk, sample_pulse at the end of clk 2 of each bit.
- Reset or enable drop mid-TSEG1: state_o=IDLE and all strobes 0 on the next clk. After enable rises with new tseg1=3, the bit length is 8 tq.
